// File: rtl/sys_bridge_n.sv
`default_nettype none
// ============================================================================
// sys_bridge_n : registered NSLV-way bus bridge, wait states, timeout, errors
// Revision     : 1.0
// ============================================================================
module sys_bridge_n #(
  parameter int                  ADDR_W   = 32,
  parameter int                  DATA_W   = 32,
  parameter int                  BE_W     = 4,
  parameter int                  NSLV     = 4,
  parameter int                  DEC_W    = 16,
  parameter logic [NSLV*DEC_W-1:0] SLV_BASE = {16'h0000, 16'h7F00, 16'h7F10, 16'h7F20},
  parameter int                  TO_CYC   = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   m_req,
  input  logic                   m_wr,
  input  logic [ADDR_W-1:0]      m_addr,
  input  logic [DATA_W-1:0]      m_din,
  input  logic [BE_W-1:0]        m_be,
  output logic                   m_ack,
  output logic                   m_err,
  output logic [DATA_W-1:0]      m_dout,
  output logic [NSLV-1:0]        s_sel,
  output logic                   s_wr,
  output logic [ADDR_W-1:0]      s_addr,
  output logic [DATA_W-1:0]      s_din,
  output logic [BE_W-1:0]        s_be,
  input  logic [NSLV*DATA_W-1:0] s_rdata,
  input  logic [NSLV-1:0]        s_ready,
  output logic [ADDR_W-1:0]      err_addr,
  output logic [7:0]             err_cnt
);

  localparam int IDX_W = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam logic [7:0] c_to_last = 8'(TO_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERR    = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [7:0]         r_wait;
  logic [IDX_W-1:0]   r_idx;
  logic [DEC_W-1:0]   w_tag;
  logic [NSLV-1:0]    w_match;
  logic               w_hit;
  logic [IDX_W-1:0]   w_hit_idx;
  logic [DATA_W-1:0]  w_rdata [NSLV];
  logic               w_sel_ready;
  logic               w_timeout;

  assign w_tag = m_addr[ADDR_W-1 -: DEC_W];

  // Field 0 of both packed vectors sits in the most significant position.
  for (genvar i = 0; i < NSLV; i++) begin : g_slv
    assign w_match[i] = (w_tag == SLV_BASE[(NSLV-1-i)*DEC_W +: DEC_W]);
    assign w_rdata[i] = s_rdata[(NSLV-1-i)*DATA_W +: DATA_W];
  end

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
    end
  end

  assign w_sel_ready = s_ready[r_idx];
  assign w_timeout   = (r_wait == c_to_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (m_req) begin
          w_next = w_hit ? ACCESS : ERR;
        end
      end
      ACCESS: begin
        if (w_sel_ready) begin
          w_next = DONE;
        end else if (w_timeout) begin
          w_next = ERR;
        end
      end
      DONE:    w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ack    <= 1'b0;
      m_err    <= 1'b0;
      m_dout   <= '0;
      s_sel    <= '0;
      s_wr     <= 1'b0;
      s_addr   <= '0;
      s_din    <= '0;
      s_be     <= '0;
      err_addr <= '0;
      err_cnt  <= 8'd0;
      r_wait   <= 8'd0;
      r_idx    <= '0;
    end else begin
      m_ack <= 1'b0;
      m_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (m_req) begin
            if (w_hit) begin
              s_addr <= m_addr;
              s_din  <= m_din;
              s_be   <= m_be;
              s_wr   <= m_wr;
              s_sel  <= {{(NSLV-1){1'b0}}, 1'b1} << w_hit_idx;
              r_idx  <= w_hit_idx;
              r_wait <= 8'd0;
            end else begin
              err_addr <= m_addr;
            end
          end
        end
        ACCESS: begin
          if (w_sel_ready) begin
            m_dout <= w_rdata[r_idx];
            s_sel  <= '0;
            s_wr   <= 1'b0;
          end else if (w_timeout) begin
            s_sel    <= '0;
            s_wr     <= 1'b0;
            err_addr <= s_addr;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        DONE: begin
          m_ack <= 1'b1;
        end
        ERR: begin
          m_ack  <= 1'b1;
          m_err  <= 1'b1;
          m_dout <= '1;
          if (err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
          end
        end
        default: begin
          m_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sys_bridge_n.sv
`default_nettype none
// tb_sys_bridge_n: directed + randomized bench for sys_bridge_n, checked
// against a transaction-level model of decode, latency and error rules.
module tb_sys_bridge_n;

  localparam int NSLV   = 4;
  localparam int TO_CYC = 15;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         m_req;
  logic         m_wr;
  logic [31:0]  m_addr;
  logic [31:0]  m_din;
  logic [3:0]   m_be;
  logic         m_ack;
  logic         m_err;
  logic [31:0]  m_dout;
  logic [3:0]   s_sel;
  logic         s_wr;
  logic [31:0]  s_addr;
  logic [31:0]  s_din;
  logic [3:0]   s_be;
  logic [127:0] s_rdata;
  logic [3:0]   s_ready;
  logic [31:0]  err_addr;
  logic [7:0]   err_cnt;

  int          checks = 0;
  int          errors = 0;
  int          exp_errcnt = 0;
  logic [31:0] last_dout = '0;
  logic [31:0] rd [4];

  sys_bridge_n dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m_req    (m_req),
    .m_wr     (m_wr),
    .m_addr   (m_addr),
    .m_din    (m_din),
    .m_be     (m_be),
    .m_ack    (m_ack),
    .m_err    (m_err),
    .m_dout   (m_dout),
    .s_sel    (s_sel),
    .s_wr     (s_wr),
    .s_addr   (s_addr),
    .s_din    (s_din),
    .s_be     (s_be),
    .s_rdata  (s_rdata),
    .s_ready  (s_ready),
    .err_addr (err_addr),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Address map as a lookup table: first listed base that matches wins.
  function automatic int decode(input logic [31:0] a);
    logic [15:0] bases [4];
    bases = '{16'h0000, 16'h7F00, 16'h7F10, 16'h7F20};
    for (int i = 0; i < NSLV; i++) begin
      if (a[31:16] == bases[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_rdata();
    s_rdata = {rd[0], rd[1], rd[2], rd[3]};
  endtask

  task automatic new_rdata();
    for (int i = 0; i < NSLV; i++) rd[i] = $urandom;
    set_rdata();
  endtask

  // Issues one request and follows it to its ack; leaves m_req high so the
  // caller may either idle() or chain another request back-to-back.
  task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [31:0] din,
                         input logic [3:0] be, input int waits);
    int          idx;
    int          exp_lat;
    int          exp_sel;
    logic        exp_err;
    logic [31:0] exp_dout;
    logic [3:0]  onehot;
    int          cyc;
    int          sel_cyc;
    bit          acked;
    idx = decode(addr);
    if (idx < 0) begin
      exp_lat = 1; exp_sel = 0; exp_err = 1'b1;
    end else if (waits >= TO_CYC) begin
      exp_lat = TO_CYC + 1; exp_sel = TO_CYC; exp_err = 1'b1;
    end else begin
      exp_lat = waits + 2; exp_sel = waits + 1; exp_err = 1'b0;
    end
    onehot   = '0;
    exp_dout = '1;
    if (idx >= 0) begin
      onehot = 4'(1) << idx;
      if (!exp_err) exp_dout = rd[idx];
    end
    m_req = 1'b1; m_wr = wr; m_addr = addr; m_din = din; m_be = be;
    s_ready = 4'($urandom) & ~onehot;
    cyc = 0; sel_cyc = 0; acked = 0;
    while (!acked && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        m_wr = 1'($urandom); m_addr = $urandom; m_din = $urandom; m_be = 4'($urandom);
      end
      if (s_sel != 4'b0) begin
        sel_cyc++;
        chk("s_sel", 32'(s_sel), 32'(onehot));
        chk("s_wr", 32'(s_wr), 32'(wr));
        chk("s_addr", s_addr, addr);
        chk("s_din", s_din, din);
        chk("s_be", 32'(s_be), 32'(be));
      end else begin
        chk("s_wr_idle", 32'(s_wr), 32'(0));
      end
      s_ready = (4'($urandom) & ~onehot) | ((s_sel != 4'b0 && sel_cyc > waits) ? onehot : 4'b0);
      if (m_ack) begin
        acked = 1;
        chk("latency", 32'(cyc - 1), 32'(exp_lat));
        chk("sel_cycles", 32'(sel_cyc), 32'(exp_sel));
        chk("m_err", 32'(m_err), 32'(exp_err));
        chk("m_dout", m_dout, exp_dout);
        if (exp_err) begin
          if (exp_errcnt < 255) exp_errcnt++;
          chk("err_addr", err_addr, addr);
        end
        chk("err_cnt", 32'(err_cnt), 32'(exp_errcnt));
        last_dout = exp_dout;
      end
    end
    if (!acked) chk("ack_timeout", 32'(m_ack), 32'(1));
  endtask

  task automatic idle();
    m_req = 1'b0;
    m_addr = $urandom;
    @(posedge clk); #1;
    chk("ack_pulse", 32'(m_ack), 32'(0));
    chk("s_sel_idle", 32'(s_sel), 32'(0));
    chk("m_dout_hold", m_dout, last_dout);
  endtask

  initial begin
    int slv;
    logic [31:0] a;
    rst_n = 1'b0; m_req = 1'b0; m_wr = 1'b0; m_addr = '0; m_din = '0; m_be = '0;
    s_ready = '0;
    new_rdata();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(m_ack), 32'(0));
    chk("rst_err", 32'(m_err), 32'(0));
    chk("rst_sel", 32'(s_sel), 32'(0));
    chk("rst_wr", 32'(s_wr), 32'(0));
    chk("rst_dout", m_dout, 32'(0));
    chk("rst_saddr", s_addr, 32'(0));
    chk("rst_sdin", s_din, 32'(0));
    chk("rst_sbe", 32'(s_be), 32'(0));
    chk("rst_erraddr", err_addr, 32'(0));
    chk("rst_errcnt", 32'(err_cnt), 32'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero-wait read of slave 0
    rd[0] = 32'hDEADBEEF; set_rdata();
    run_txn(32'h0000_0010, 1'b0, 32'h0, 4'hF, 0);
    idle();

    // Write to slave 2 with three wait states
    new_rdata();
    run_txn(32'h7F10_0004, 1'b1, 32'h1234_5678, 4'b0011, 3);
    idle();

    // Unmapped read
    run_txn(32'h4000_0000, 1'b0, 32'h0, 4'hF, 0);
    idle();

    // Slave 1 never ready -> timeout
    new_rdata();
    run_txn(32'h7F00_ABCD, 1'b0, 32'h0, 4'hF, 99);
    idle();

    // Ready on the very last permitted wait cycle
    new_rdata();
    run_txn(32'h7F20_0100, 1'b0, 32'h0, 4'hF, TO_CYC - 1);
    idle();

    // Back-to-back reads, slave 0 then slave 3
    new_rdata();
    run_txn(32'h0000_0200, 1'b0, 32'h0, 4'hF, 1);
    run_txn(32'h7F20_0008, 1'b0, 32'h0, 4'hF, 0);
    idle();

    // Randomized mix of slaves, misses, wait counts and chaining
    for (int n = 0; n < 40; n++) begin
      new_rdata();
      slv = int'($urandom_range(0, 4));
      case (slv)
        0:       a = {16'h0000, 16'($urandom)};
        1:       a = {16'h7F00, 16'($urandom)};
        2:       a = {16'h7F10, 16'($urandom)};
        3:       a = {16'h7F20, 16'($urandom)};
        default: a = {4'h8, 28'($urandom)};
      endcase
      run_txn(a, 1'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, TO_CYC + 1)));
      if ($urandom_range(0, 2) != 0) idle();
    end
    idle();

    // Drive the error counter into saturation
    for (int n = 0; n < 300; n++) begin
      run_txn({16'h4000, 16'($urandom)}, 1'b0, 32'h0, 4'hF, 0);
      idle();
    end
    chk("err_cnt_sat", 32'(err_cnt), 32'(255));

    // Reset asserted while a slave is holding off the access
    m_req = 1'b1; m_wr = 1'b1; m_addr = 32'h7F00_1234; m_din = 32'hCAFE_F00D; m_be = 4'hF;
    s_ready = 4'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("mid_sel", 32'(s_sel), 32'(4'b0010));
    rst_n = 1'b0;
    #1;
    chk("arst_sel", 32'(s_sel), 32'(0));
    chk("arst_wr", 32'(s_wr), 32'(0));
    chk("arst_ack", 32'(m_ack), 32'(0));
    chk("arst_errcnt", 32'(err_cnt), 32'(0));
    chk("arst_dout", m_dout, 32'(0));
    exp_errcnt = 0;
    last_dout  = '0;
    m_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_sel", 32'(s_sel), 32'(0));
    chk("post_rst_ack", 32'(m_ack), 32'(0));
    new_rdata();
    run_txn(32'h7F20_0040, 1'b0, 32'h0, 4'hF, 2);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
